// File: rtl/noc_pkg.sv
// noc_pkg: packet info codes, packet field offsets and the adapter FSM state type.
package noc_pkg;
  localparam int INFO_CONFIG    = 1;
  localparam int INFO_CALC      = 2;
  localparam int INFO_BCAST     = 3;
  localparam int INFO_FIN_BCAST = 4;
  localparam int INFO_FIN_COMP  = 5;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DRAIN} state_t;

  function automatic int addr_lsb(input int dw);
    return dw;
  endfunction

  function automatic int info_lsb(input int aw, input int dw);
    return aw + dw;
  endfunction
endpackage

// File: rtl/ni_out_fifo.sv
// ni_out_fifo: dual-write single-read packet queue; a write finding no free slot is dropped.
module ni_out_fifo #(
  parameter int W = 36,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we0,
  input  logic [W-1:0]  d0,
  input  logic          we1,
  input  logic [W-1:0]  d1,
  input  logic          re,
  output logic [W-1:0]  head,
  output logic [AW:0]   count
);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] free;
  logic acc0, acc1;

  // Space is judged on the occupancy at the start of the cycle; a same-cycle read does not free a slot.
  always_comb begin
    free = (AW+1)'(DEPTH) - count;
    acc0 = we0 && free != '0;
    acc1 = we1 && free > (AW+1)'(acc0);
  end

  assign head = mem[rd];

  always_ff @(posedge clk) begin
    if (acc0) mem[wr] <= d0;
    if (acc1) mem[wr + AW'(acc0)] <= d1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      wr <= wr + AW'(acc0) + AW'(acc1);
      rd <= rd + AW'(re);
      count <= count + (AW+1)'(acc0) + (AW+1)'(acc1) - (AW+1)'(re);
    end
endmodule

// File: rtl/pe_noc_adapter.sv
// pe_noc_adapter: bridges a router local port to a PE (config writes, control pulses, credits, output queue).
// Define NI_ERR_STATUS_EN to implement the sticky err_status bits {credit_ovf, oq_ovf, bad_info}.
module pe_noc_adapter
  import noc_pkg::*;
#(
  parameter int PE_IDX = 0,
  parameter int INFO_W = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int ACT_AW = 6,
  parameter int CREDIT_DEPTH = 4,
  parameter int OQ_DEPTH = 4,
  localparam int PKT_W = INFO_W + ADDR_W + DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [PKT_W-1:0]         in_pkt,
  output logic                     out_valid,
  output logic [PKT_W-1:0]         out_pkt,
  input  logic                     downstream_credit,
  output logic                     upstream_credit,
  output logic                     cfg_we,
  output logic [3:0]               cfg_addr,
  output logic [DATA_W-1:0]        cfg_data,
  output logic                     act_we,
  output logic [ACT_AW-1:0]        act_waddr,
  output logic [DATA_W-1:0]        act_wdata,
  output logic                     pe_start_calc,
  output logic                     fin_broadcast,
  output logic                     layer_done,
  input  logic                     fin_comp,
  input  logic                     act_send_en,
  input  logic [ADDR_W-1:0]        act_send_addr,
  input  logic [DATA_W-1:0]        act_send_data,
  output logic                     router_rdy,
  input  logic                     pop_act,
  output logic                     push_act,
  output logic [ADDR_W+DATA_W-1:0] act,
  output logic                     pe_busy,
  output logic [2:0]               err_status
);
  localparam int CW = $clog2(CREDIT_DEPTH) + 1;
  localparam int QW = $clog2(OQ_DEPTH) + 1;
  localparam int IL = info_lsb(ADDR_W, DATA_W);
  localparam int AL = addr_lsb(DATA_W);

  logic [INFO_W-1:0] info;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic v, is_cfg, is_calc, is_bc, is_fb, is_fc, cfg_wr, act_wr, deq, cr_acc, fc_en;
  logic [CW-1:0] owed, credit_count;
  logic [QW-1:0] count;
  logic [PKT_W-1:0] head, act_pkt;
  state_t state;
  logic fin_seen;

  always_comb begin
    info = in_pkt[IL +: INFO_W];
    addr = in_pkt[AL +: ADDR_W];
    data = in_pkt[DATA_W-1:0];
    v = rst && in_valid;
    is_cfg = v && info == INFO_W'(INFO_CONFIG);
    is_calc = v && info == INFO_W'(INFO_CALC);
    is_bc = v && info == INFO_W'(INFO_BCAST);
    is_fb = v && info == INFO_W'(INFO_FIN_BCAST);
    is_fc = v && info == INFO_W'(INFO_FIN_COMP);
    cfg_wr = is_cfg && !addr[7];
    act_wr = is_cfg && addr[7];
    deq = count != '0 && credit_count != '0;
    cr_acc = downstream_credit && credit_count != CW'(CREDIT_DEPTH);
    fc_en = fin_comp && state == ST_CALC;
    act_pkt = {act_send_addr[ADDR_W-1] ? INFO_W'(INFO_FIN_BCAST) : INFO_W'(INFO_BCAST),
               act_send_addr, act_send_data};
    push_act = is_bc;
    act = is_bc ? {addr, data} : '0;
    upstream_credit = owed != '0;
    router_rdy = rst && count <= QW'(OQ_DEPTH - 2);
    pe_busy = state != ST_IDLE;
  end

  ni_out_fifo #(.W(PKT_W), .DEPTH(OQ_DEPTH)) u_oq (
    .clk(clk),
    .rst(rst),
    .we0(act_send_en),
    .d0(act_pkt),
    .we1(fc_en),
    .d1({INFO_W'(INFO_FIN_COMP), ADDR_W'(0), DATA_W'(PE_IDX)}),
    .re(deq),
    .head(head),
    .count(count)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cfg_we <= 1'b0;
      cfg_addr <= '0;
      cfg_data <= '0;
      act_we <= 1'b0;
      act_waddr <= '0;
      act_wdata <= '0;
      pe_start_calc <= 1'b0;
      fin_broadcast <= 1'b0;
      layer_done <= 1'b0;
      owed <= '0;
      credit_count <= CW'(CREDIT_DEPTH);
      out_valid <= 1'b0;
      out_pkt <= '0;
      state <= ST_IDLE;
      fin_seen <= 1'b0;
    end else begin
      cfg_we <= cfg_wr;
      cfg_addr <= cfg_wr ? addr[3:0] : '0;
      cfg_data <= cfg_wr ? data : '0;
      act_we <= act_wr;
      act_waddr <= act_wr ? addr[ACT_AW:1] : '0;
      act_wdata <= act_wr ? data : '0;
      pe_start_calc <= is_calc;
      fin_broadcast <= is_fb;
      layer_done <= is_fc;
      // Broadcasts are credited back later via pop_act; every other packet is credited at once.
      owed <= owed + CW'(v && !is_bc) + CW'(pop_act) - CW'(owed != '0);
      credit_count <= credit_count - CW'(deq) + CW'(cr_acc);
      out_valid <= deq;
      out_pkt <= deq ? head : '0;
      case (state)
        ST_IDLE: if (is_calc) state <= ST_CALC;
        ST_CALC: if (fin_comp) state <= ST_DRAIN;
        ST_DRAIN: if (fin_seen && count == '0) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      fin_seen <= (state == ST_DRAIN && fin_seen && count == '0) ? 1'b0
                : fin_seen | (is_fc && state != ST_IDLE);
    end

`ifdef NI_ERR_STATUS_EN
  logic [QW-1:0] free;
  logic oq_ovf;

  always_comb begin
    free = QW'(OQ_DEPTH) - count;
    oq_ovf = (QW'(act_send_en) + QW'(fc_en)) > free;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) err_status <= '0;
    else err_status <= err_status | {downstream_credit && !cr_acc, oq_ovf,
                                     v && !(is_cfg || is_calc || is_bc || is_fb || is_fc)};
`else
  assign err_status = '0;
`endif
endmodule

// File: tb/tb_pe_noc_adapter.sv
// tb_pe_noc_adapter: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_pe_noc_adapter;
  localparam int PW = 36;
`ifdef NI_ERR_STATUS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, downstream_credit = 1'b0, fin_comp = 1'b0, act_send_en = 1'b0, pop_act = 1'b0;
  logic [PW-1:0] in_pkt = '0;
  logic [15:0] act_send_addr = '0, act_send_data = '0;
  logic out_valid, upstream_credit, cfg_we, act_we, pe_start_calc, fin_broadcast, layer_done;
  logic router_rdy, push_act, pe_busy;
  logic [PW-1:0] out_pkt;
  logic [3:0] cfg_addr;
  logic [15:0] cfg_data, act_wdata;
  logic [5:0] act_waddr;
  logic [31:0] act;
  logic [2:0] err_status;
  int n_err = 0, n_chk = 0;

  pe_noc_adapter #(.PE_IDX(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_pkt(out_pkt),
    .downstream_credit(downstream_credit), .upstream_credit(upstream_credit),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .act_we(act_we), .act_waddr(act_waddr), .act_wdata(act_wdata),
    .pe_start_calc(pe_start_calc), .fin_broadcast(fin_broadcast), .layer_done(layer_done),
    .fin_comp(fin_comp), .act_send_en(act_send_en), .act_send_addr(act_send_addr),
    .act_send_data(act_send_data), .router_rdy(router_rdy), .pop_act(pop_act),
    .push_act(push_act), .act(act), .pe_busy(pe_busy), .err_status(err_status)
  );

  always #5 clk = ~clk;

  logic [PW-1:0] m_q[$];
  int m_credit, m_owed, m_st;
  bit m_fin;
  logic [2:0] m_err;
  logic e_ov, e_cw, e_aw, e_s, e_fb, e_ld;
  logic [PW-1:0] e_pkt;
  logic [3:0] e_ca;
  logic [5:0] e_wa;
  logic [15:0] e_cd, e_wd;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_credit = 4; m_owed = 0; m_st = 0; m_fin = 0; m_err = '0;
    e_ov = 0; e_pkt = '0; e_cw = 0; e_ca = '0; e_cd = '0; e_aw = 0; e_wa = '0; e_wd = '0;
    e_s = 0; e_fb = 0; e_ld = 0;
  endtask

  // One clock of the adapter's rules, applied to the inputs currently on the pins.
  task automatic model_step();
    logic [3:0] inf;
    logic [15:0] ad, dt;
    bit v, cfg, bad, deq, ovf, crovf;
    int n0, room, nst;
    inf = in_pkt[35:32]; ad = in_pkt[31:16]; dt = in_pkt[15:0]; v = in_valid;
    cfg = v && inf == 4'd1;
    e_cw = cfg && !ad[7]; e_ca = e_cw ? ad[3:0] : 4'd0; e_cd = e_cw ? dt : 16'd0;
    e_aw = cfg && ad[7]; e_wa = e_aw ? ad[6:1] : 6'd0; e_wd = e_aw ? dt : 16'd0;
    e_s = v && inf == 4'd2; e_fb = v && inf == 4'd4; e_ld = v && inf == 4'd5;
    bad = v && (inf == 4'd0 || inf > 4'd5);
    m_owed = m_owed + int'(v && inf != 4'd3) + int'(pop_act) - int'(m_owed > 0);
    n0 = m_q.size();
    deq = n0 > 0 && m_credit > 0;
    e_ov = deq;
    e_pkt = '0;
    if (deq) e_pkt = m_q.pop_front();
    room = 4 - n0;
    ovf = 0;
    if (act_send_en) begin
      if (room > 0) begin
        m_q.push_back({act_send_addr[15] ? 4'd4 : 4'd3, act_send_addr, act_send_data});
        room--;
      end else ovf = 1;
    end
    if (fin_comp && m_st == 1) begin
      if (room > 0) m_q.push_back({4'd5, 16'd0, 16'd5});
      else ovf = 1;
    end
    crovf = downstream_credit && m_credit == 4;
    m_credit = m_credit - int'(deq) + int'(downstream_credit && !crovf);
    m_err = m_err | {crovf, ovf, bad};
    nst = m_st;
    if (m_st == 0 && e_s) nst = 1;
    else if (m_st == 1 && fin_comp) nst = 2;
    else if (m_st == 2 && m_fin && n0 == 0) nst = 0;
    m_fin = (nst == 0) ? 0 : (m_fin || (e_ld && m_st != 0));
    m_st = nst;
  endtask

  task automatic cyc();
    bit pa;
    #4;
    pa = rst && in_valid && in_pkt[35:32] == 4'd3;
    chk("push_act", push_act, pa);
    chk("act", act, pa ? in_pkt[31:0] : 32'd0);
    chk("router_rdy", router_rdy, rst && m_q.size() <= 2);
    chk("upstream_credit", upstream_credit, m_owed > 0);
    chk("pe_busy", pe_busy, m_st != 0);
    if (rst) model_step(); else model_reset();
    @(posedge clk); #1;
    chk("out_valid", out_valid, e_ov);
    chk("out_pkt", out_pkt, e_pkt);
    chk("cfg_we", cfg_we, e_cw);
    chk("cfg_addr", cfg_addr, e_ca);
    chk("cfg_data", cfg_data, e_cd);
    chk("act_we", act_we, e_aw);
    chk("act_waddr", act_waddr, e_wa);
    chk("act_wdata", act_wdata, e_wd);
    chk("pe_start_calc", pe_start_calc, e_s);
    chk("fin_broadcast", fin_broadcast, e_fb);
    chk("layer_done", layer_done, e_ld);
    chk("err_status", err_status, ERR_EN ? m_err : 3'd0);
    in_valid = 0; in_pkt = '0; downstream_credit = 0; fin_comp = 0;
    act_send_en = 0; act_send_addr = '0; act_send_data = '0; pop_act = 0;
  endtask

  task automatic send_pkt(input logic [3:0] i, input logic [15:0] a, input logic [15:0] d);
    in_valid = 1; in_pkt = {i, a, d};
    cyc();
  endtask

  task automatic send_act(input logic [15:0] a, input logic [15:0] d);
    act_send_en = 1; act_send_addr = a; act_send_data = d;
    cyc();
  endtask

  typedef struct {
    logic [3:0] info; logic [15:0] addr, data;
    logic cw; logic [3:0] ca; logic aw; logic [5:0] wa; logic [15:0] wd;
    logic s, fb, ld;
  } vec_t;
  vec_t tbl[7];

  initial begin
    int outs;
    logic [PW-1:0] last;
    int codes[8];
    codes = '{1, 2, 3, 3, 4, 5, 9, 0};
    tbl[0] = '{4'd1, 16'h0085, 16'h1234, 1'b0, 4'h0, 1'b1, 6'd2,  16'h1234, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd1, 16'h0003, 16'hBEEF, 1'b1, 4'h3, 1'b0, 6'd0,  16'hBEEF, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'd1, 16'h00FF, 16'h0001, 1'b0, 4'h0, 1'b1, 6'd63, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'd1, 16'h007C, 16'h5555, 1'b1, 4'hC, 1'b0, 6'd0,  16'h5555, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'd4, 16'h1234, 16'h0000, 1'b0, 4'h0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'd5, 16'h0000, 16'h0007, 1'b0, 4'h0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{4'd9, 16'h0080, 16'h0001, 1'b0, 4'h0, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b0, 1'b0};

    #1 rst = 0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_credit_count", dut.credit_count, 4);
    chk("rst_router_rdy", router_rdy, 0);
    chk("rst_err_status", err_status, 0);
    repeat (2) cyc();
    rst = 1;

    for (int i = 0; i < 7; i++) begin
      send_pkt(tbl[i].info, tbl[i].addr, tbl[i].data);
      chk($sformatf("tbl%0d_cfg_we", i), cfg_we, tbl[i].cw);
      chk($sformatf("tbl%0d_cfg_addr", i), cfg_addr, tbl[i].ca);
      chk($sformatf("tbl%0d_cfg_data", i), cfg_data, tbl[i].cw ? tbl[i].wd : 16'd0);
      chk($sformatf("tbl%0d_act_we", i), act_we, tbl[i].aw);
      chk($sformatf("tbl%0d_act_waddr", i), act_waddr, tbl[i].wa);
      chk($sformatf("tbl%0d_act_wdata", i), act_wdata, tbl[i].aw ? tbl[i].wd : 16'd0);
      chk($sformatf("tbl%0d_start", i), pe_start_calc, tbl[i].s);
      chk($sformatf("tbl%0d_fin_bc", i), fin_broadcast, tbl[i].fb);
      chk($sformatf("tbl%0d_layer_done", i), layer_done, tbl[i].ld);
      chk($sformatf("tbl%0d_upstream_credit", i), upstream_credit, 1);
    end
    chk("bad_info", err_status[0], ERR_EN);
    repeat (3) cyc();

    pop_act = 1;
    send_pkt(4'd4, 16'h0001, 16'h0002);
    chk("dual_credit_c1", upstream_credit, 1);
    cyc();
    chk("dual_credit_c2", upstream_credit, 1);
    cyc();
    chk("dual_credit_c3", upstream_credit, 0);

    send_pkt(4'd2, 16'h0000, 16'h0000);
    chk("calc_pulse", pe_start_calc, 1);
    chk("calc_busy", pe_busy, 1);
    fin_comp = 1;
    send_act(16'h0003, 16'hABCD);
    chk("drain_out0", out_valid, 0);
    cyc();
    chk("drain_bc_valid", out_valid, 1);
    chk("drain_bc_pkt", out_pkt, 36'h3_0003_ABCD);
    cyc();
    chk("drain_fc_valid", out_valid, 1);
    chk("drain_fc_pkt", out_pkt, 36'h5_0000_0005);
    send_pkt(4'd5, 16'h0000, 16'h0005);
    chk("drain_busy", pe_busy, 1);
    cyc();
    chk("drain_idle", pe_busy, 0);
    repeat (2) begin downstream_credit = 1; cyc(); end
    downstream_credit = 1;
    cyc();
    chk("credit_ovf", err_status[2], ERR_EN);

    outs = 0;
    for (int i = 0; i < 5; i++) begin
      send_act(16'h0010 + 16'(i), 16'h0100 + 16'(i));
      outs += int'(out_valid);
    end
    repeat (10) begin cyc(); outs += int'(out_valid); end
    chk("held_outputs", outs, 4);
    downstream_credit = 1;
    cyc();
    outs += int'(out_valid);
    last = '0;
    repeat (3) begin
      cyc();
      outs += int'(out_valid);
      if (out_valid) last = out_pkt;
    end
    chk("released_outputs", outs, 5);
    chk("released_pkt", last, 36'h3_0014_0104);

    for (int k = 1; k <= 6; k++) begin
      send_act(16'h0020 + 16'(k), 16'(k));
      if (k == 2) chk("rdy_after2", router_rdy, 1);
      if (k == 3) chk("rdy_after3", router_rdy, 0);
    end
    chk("oq_ovf", err_status[1], ERR_EN);
    outs = 0;
    repeat (4) begin downstream_credit = 1; cyc(); outs += int'(out_valid); end
    repeat (6) begin cyc(); outs += int'(out_valid); end
    chk("ovf_delivered", outs, 4);

    send_pkt(4'd2, 16'h0000, 16'h0000);
    send_act(16'h0040, 16'h0001);
    send_act(16'h0041, 16'h0002);
    chk("pre_reset_busy", pe_busy, 1);
    rst = 0;
    model_reset();
    #2;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_credit", dut.credit_count, 4);
    chk("midrst_busy", pe_busy, 0);
    cyc();
    rst = 1;
    outs = 0;
    repeat (5) begin cyc(); outs += int'(out_valid); end
    chk("post_reset_outputs", outs, 0);

    for (int n = 0; n < 3000; n++) begin
      in_valid = $urandom_range(0, 3) == 0;
      in_pkt = {4'(codes[$urandom_range(0, 7)]), 16'($urandom), 16'($urandom)};
      pop_act = $urandom_range(0, 7) == 0;
      downstream_credit = $urandom_range(0, 2) == 0;
      act_send_en = $urandom_range(0, 2) == 0;
      act_send_addr = 16'($urandom);
      act_send_data = 16'($urandom);
      fin_comp = $urandom_range(0, 4) == 0;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_noc_adapter.md
PE_NOC_ADAPTER -- requirements
Module: pe_noc_adapter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- PE_IDX, 0, PE index placed in the FIN_COMP payload.
- INFO_W, 4, packet info field width.
- ADDR_W, 16, packet address field width.
- DATA_W, 16, packet data field width.
- ACT_AW, 6, input-activation write address width.
- CREDIT_DEPTH, 4, downstream router FIFO depth.
- OQ_DEPTH, 4, output queue depth (power of two, >=2).
REQ-002 Packet width SHALL be PKT_W=INFO_W+ADDR_W+DATA_W, laid out as {info,addr,data} with info in the MSBs.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-low.
- in_valid, in, 1, router local-port packet valid.
- in_pkt, in, PKT_W, incoming packet.
- out_valid, out, 1, outgoing packet valid.
- out_pkt, out, PKT_W, outgoing packet.
- downstream_credit, in, 1, credit returned by the router.
- upstream_credit, out, 1, credit returned to the router.
- cfg_we / cfg_addr / cfg_data, out, 1/4/DATA_W, PE status register write.
- act_we / act_waddr / act_wdata, out, 1/ACT_AW/DATA_W, input-activation write.
- pe_start_calc / fin_broadcast / layer_done, out, 1 each, control pulses.
- fin_comp, in, 1, PE finished computation.
- act_send_en / act_send_addr / act_send_data, in, 1/ADDR_W/DATA_W, activation send request.
- router_rdy, out, 1, at least 2 free output-queue entries.
- pop_act, in, 1, activation queue popped.
- push_act / act, out, 1/(PE address bits + DATA_W), activation queue push.
- pe_busy, out, 1, FSM not in IDLE.
- err_status, out, 3, sticky errors {credit_ovf, oq_ovf, bad_info}.

Function
REQ-004 CONFIG packets SHALL register, 1 cycle after accept:
- addr[7]=0: cfg_we=1, cfg_addr=addr[3:0].
- addr[7]=1: act_we=1, act_waddr=addr[ACT_AW:1].
- All other cycles: write strobes, addresses and data SHALL be zero.
REQ-005 CALC, FIN_BROADCAST and FIN_COMP packets SHALL each produce a 1-cycle registered pulse on pe_start_calc, fin_broadcast and layer_done respectively.
REQ-006 BROADCAST packets SHALL drive push_act and act combinationally in the same cycle.
REQ-007 Upstream credit SHALL use an owed-credit counter, width clog2(CREDIT_DEPTH)+1:
- +1 per accepted non-BROADCAST packet; +1 per pop_act; both in one cycle give +2.
- upstream_credit=1 and the counter decrements by 1 whenever owed>0, so no credit is lost on coincident events.
REQ-008 Output queue SHALL be an OQ_DEPTH FIFO:
- act_send_en enqueues FIN_BROADCAST if act_send_addr MSB=1, otherwise BROADCAST, with addr/data as given.
- fin_comp enqueues {FIN_COMP, 0, PE_IDX}.
- If both in the same cycle, the act packet enqueues first, then FIN_COMP (2 writes).
REQ-009 Dequeue SHALL occur when the queue is non-empty and credit_count>0:
- out_valid/out_pkt are registered, 1-cycle latency.
- Otherwise out_valid=0 and out_pkt=0.
REQ-010 credit_count SHALL reset to CREDIT_DEPTH; it decrements on dequeue, increments on downstream_credit, and is unchanged when both occur.
REQ-011 A downstream_credit arriving with credit_count=CREDIT_DEPTH SHALL be dropped and set credit_ovf.
REQ-012 An enqueue to a full queue SHALL drop that packet and set oq_ovf; the queue pointers wrap modulo OQ_DEPTH.
REQ-013 An unknown info code SHALL still return a credit and set bad_info.
REQ-014 FSM states SHALL be IDLE, CALC, DRAIN:
- IDLE->CALC on a CALC packet.
- CALC->DRAIN on fin_comp.
- DRAIN->IDLE when the queue is empty and a FIN_COMP packet has been received.
- fin_comp outside CALC SHALL be ignored (not enqueued).

Reset
REQ-015 While rst=0, all outputs, the FSM (IDLE), queue pointers, owed counter and err_status SHALL be 0, and credit_count SHALL be CREDIT_DEPTH.
REQ-016 Reset asserted mid-operation SHALL discard queued packets and owed credits.

Configuration
REQ-017 With NI_ERR_STATUS_EN defined, err_status SHALL be implemented as sticky bits cleared only by reset; undefined, err_status SHALL be tied to 0 and the detection logic omitted, while drop behaviour stays unchanged.

Structure
REQ-018 Info codes, the field-offset functions and the FSM state enum SHALL live in shared package noc_pkg.
REQ-019 The output queue SHALL be sub-module ni_out_fifo (dual-write, single-read).

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- CONFIG addr=0x0085, data=0x1234 -> next cycle act_we=1, act_waddr=2, act_wdata=0x1234; upstream_credit=1.
- FIN_BROADCAST and pop_act in the same cycle -> upstream_credit=1 for 2 consecutive cycles.
- In CALC, act_send_en addr=0x0003 plus fin_comp same cycle, PE_IDX=5 -> out_pkt BROADCAST, then {FIN_COMP,0,5}.
- No downstream credits returned: 5 sends with CREDIT_DEPTH=4 -> 4 outputs, 5th held until a credit arrives.
- 6 enqueues without credits, OQ_DEPTH=4 -> router_rdy=0 after 3; oq_ovf=1; 4 packets delivered.
- Reset pulse with 2 packets queued -> out_valid=0, credit_count=4, pe_busy=0.
